// File: rtl/width_conv_pkg.sv
// -----------------------------------------------------------------------------
// width_conv_pkg
// Constants and helpers shared by the 64<->256 AXI4-Stream width converters
// (width_combiner and width_divider).
//   NARROW_W / WIDE_W : default narrow (MAC side) and wide (datapath) widths
//   RATIO             : number of narrow lanes per wide word
//   LANE_W            : width of a lane index
//   keep_contiguous() : 1 when a narrow tkeep is a run of ones from bit 0
//   lane_onehot()     : one-hot lane select, used to steer a beat into a lane
// The converters' width parameters must stay consistent with these constants.
// -----------------------------------------------------------------------------
package width_conv_pkg;

   localparam int NARROW_W      = 64;
   localparam int WIDE_W        = 256;
   localparam int NARROW_KEEP_W = NARROW_W / 8;
   localparam int RATIO         = WIDE_W / NARROW_W;
   localparam int LANE_W        = (RATIO > 1) ? $clog2(RATIO) : 1;

   // A keep is contiguous when no set bit appears above a cleared one.
   // All-zero keep counts as contiguous (empty beat).
   function automatic logic keep_contiguous(input logic [NARROW_KEEP_W-1:0] keep);
      logic seen_zero;
      logic ok;
      seen_zero = 1'b0;
      ok        = 1'b1;
      for (int i = 0; i < NARROW_KEEP_W; i++) begin
         if (!keep[i]) begin
            seen_zero = 1'b1;
         end else if (seen_zero) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

   function automatic logic [RATIO-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
      logic [RATIO-1:0] sel;
      sel       = '0;
      sel[lane] = 1'b1;
      return sel;
   endfunction

endpackage

// File: rtl/width_combiner_if.sv
// -----------------------------------------------------------------------------
// width_combiner_if
// AXI4-Stream bundle used on both sides of width_combiner.
//   Parameters: DATA_W (tdata width, multiple of 8), USER_W (tuser width).
//   Signals   : tdata, tkeep (DATA_W/8), tuser, tvalid, tlast, tready.
//   Modports  : master drives the payload and valid, slave drives ready.
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high. A master holding tvalid high keeps its payload unchanged
// until the transfer happens; tready may change freely.
// -----------------------------------------------------------------------------
interface width_combiner_if #(
   parameter int DATA_W = 64,
   parameter int USER_W = 1
) ();

   logic [DATA_W-1:0]   tdata;
   logic [DATA_W/8-1:0] tkeep;
   logic [USER_W-1:0]   tuser;
   logic                tvalid;
   logic                tlast;
   logic                tready;

   modport master (
      output tdata,
      output tkeep,
      output tuser,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tkeep,
      input  tuser,
      input  tvalid,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/axis_out_slice.sv
// -----------------------------------------------------------------------------
// axis_out_slice
// Single-entry registered output slice with a valid/ready handshake.
//   clk, reset   : clock, synchronous active-high reset
//   in_valid     : load request (only honoured while in_ready is high)
//   in_ready     : slice can accept a payload this cycle
//   in_payload   : payload to load
//   out_valid    : slice holds a payload
//   out_ready    : downstream takes the payload this cycle
//   out_payload  : held payload (zero while empty)
// A load and a drain in the same cycle are allowed: the new payload replaces
// the departing one, so the slice sustains one transfer per cycle.
// -----------------------------------------------------------------------------
module axis_out_slice #(
   parameter int PAYLOAD_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_payload
);

   // Ready is only blocked by a held word that downstream is not taking.
   assign in_ready = !out_valid | out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_payload <= '0;
      end else if (in_valid && in_ready) begin
         out_valid   <= 1'b1;
         out_payload <= in_payload;
      end else if (out_valid && out_ready) begin
         out_valid   <= 1'b0;
         out_payload <= '0;
      end
   end

endmodule

// File: rtl/width_combiner.sv
// -----------------------------------------------------------------------------
// width_combiner
// Packs 64-bit AXI4-Stream beats into 256-bit words, little-endian by lane
// (first beat of a word in bits [63:0]). A word is emitted when its last lane
// fills or when a beat with tlast arrives; unfilled lanes carry zero tkeep.
//   clk, reset : clock, synchronous active-high reset
//   s_axis     : narrow input stream (slave modport)
//   m_axis     : wide output stream (master modport); tuser is the tuser of
//                the word's first beat, tlast marks the packet's last word
//   err_keep   : sticky tkeep protocol error
// Optional feature macro: WIDTH_COMBINER_KEEP_CHECK_EN. When defined, err_keep
// sets on an accepted non-last beat whose tkeep is not all ones, or on any
// accepted beat with non-contiguous tkeep, and holds until reset. Data is
// never altered by the check. When undefined, err_keep is constant 0.
// -----------------------------------------------------------------------------
module width_combiner
   import width_conv_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH = NARROW_W,
   parameter int C_M_AXIS_DATA_WIDTH = WIDE_W,
   parameter int C_TUSER_WIDTH       = 1
) (
   input  logic              clk,
   input  logic              reset,
   width_combiner_if.slave   s_axis,
   width_combiner_if.master  m_axis,
   output logic              err_keep
);

   localparam int S_KEEP_W  = C_S_AXIS_DATA_WIDTH / 8;
   localparam int M_KEEP_W  = C_M_AXIS_DATA_WIDTH / 8;
   localparam int PAYLOAD_W = 1 + C_TUSER_WIDTH + M_KEEP_W + C_M_AXIS_DATA_WIDTH;

   // Accumulator for the word being assembled.
   logic [C_M_AXIS_DATA_WIDTH-1:0] acc_data;
   logic [M_KEEP_W-1:0]            acc_keep;
   logic [C_TUSER_WIDTH-1:0]       acc_user;
   logic [LANE_W-1:0]              lane;

   logic                           slice_ready;
   logic                           accept;
   logic                           complete;
   logic [RATIO-1:0]               lane_sel;
   logic [C_M_AXIS_DATA_WIDTH-1:0] next_data;
   logic [M_KEEP_W-1:0]            next_keep;
   logic [C_TUSER_WIDTH-1:0]       word_user;
   logic [PAYLOAD_W-1:0]           in_payload;
   logic [PAYLOAD_W-1:0]           out_payload;

   assign s_axis.tready = slice_ready;
   assign accept        = s_axis.tvalid & slice_ready;
   assign complete      = (lane == LANE_W'(RATIO - 1)) | s_axis.tlast;
   assign lane_sel      = lane_onehot(lane);

   // Accumulator contents with the current beat merged in. A beat on lane 0
   // starts a new word, so the keep of every later lane is cleared; their
   // data is left as-is because it is masked by keep downstream.
   always_comb begin
      next_data = acc_data;
      next_keep = acc_keep;
      for (int i = 0; i < RATIO; i++) begin
         if (lane_sel[i]) begin
            next_data[i*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH] = s_axis.tdata;
            next_keep[i*S_KEEP_W +: S_KEEP_W]                       = s_axis.tkeep;
         end else if (lane == '0) begin
            next_keep[i*S_KEEP_W +: S_KEEP_W] = '0;
         end
      end
   end

   // On lane 0 the latched tuser is stale; take it straight from the beat.
   assign word_user = (lane == '0) ? s_axis.tuser : acc_user;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_data <= '0;
         acc_keep <= '0;
         acc_user <= '0;
         lane     <= '0;
      end else if (accept) begin
         acc_data <= next_data;
         acc_keep <= next_keep;
         if (lane == '0) begin
            acc_user <= s_axis.tuser;
         end
         if (complete) begin
            lane <= '0;
         end else begin
            lane <= lane + LANE_W'(1);
         end
      end
   end

   assign in_payload = {s_axis.tlast, word_user, next_keep, next_data};

   axis_out_slice #(
      .PAYLOAD_W (PAYLOAD_W)
   ) u_out_slice (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (accept & complete),
      .in_ready    (slice_ready),
      .in_payload  (in_payload),
      .out_valid   (m_axis.tvalid),
      .out_ready   (m_axis.tready),
      .out_payload (out_payload)
   );

   assign {m_axis.tlast, m_axis.tuser, m_axis.tkeep, m_axis.tdata} = out_payload;

`ifdef WIDTH_COMBINER_KEEP_CHECK_EN
   logic keep_bad;
   logic err_q;

   assign keep_bad = (!s_axis.tlast && (s_axis.tkeep != '1)) ||
                     !keep_contiguous(s_axis.tkeep);

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (accept && keep_bad) begin
         err_q <= 1'b1;
      end
   end

   assign err_keep = err_q;
`else
   assign err_keep = 1'b0;
`endif

endmodule

// File: doc/width_combiner.md
# width_combiner

Upsizing AXI4-Stream converter in the 10G input path: accepts 64-bit beats from the MAC-side domain and packs them into 256-bit words for the datapath. It is the companion of the 256→64 `width_divider`, and together the two form a round-trip pair. Packing is little-endian by lane: the first accepted beat of a word lands in bits [63:0]. Packets shorter than a full word, or packet tails, are flushed on `tlast` with the unfilled lanes' tkeep cleared.

## Interface
Parameters:
- `C_S_AXIS_DATA_WIDTH`, 64: input data width; must be a multiple of 8.
- `C_M_AXIS_DATA_WIDTH`, 256: output data width; must be a power-of-two multiple of the input width (RATIO = 4 by default).
- `C_TUSER_WIDTH`, 1: sideband width, passed through.

Ports:
- `clk`, in, 1: single clock for all logic.
- `reset`, in, 1: synchronous, active-high; clears all state.
- `s_axis_tdata`, in, 64: input data.
- `s_axis_tkeep`, in, 8: byte enables; contiguous from bit 0.
- `s_axis_tuser`, in, C_TUSER_WIDTH: sideband.
- `s_axis_tvalid`, in, 1: input valid.
- `s_axis_tlast`, in, 1: last beat of packet.
- `s_axis_tready`, out, 1: input ready.
- `m_axis_tdata`, out, 256: packed word.
- `m_axis_tkeep`, out, 32: packed byte enables.
- `m_axis_tuser`, out, C_TUSER_WIDTH: sideband of the first beat of the word.
- `m_axis_tvalid`, out, 1: output valid.
- `m_axis_tlast`, out, 1: word contains the packet's last beat.
- `m_axis_tready`, in, 1: downstream ready.
- `err_keep`, out, 1: sticky tkeep-protocol error (see Configuration).

## Operation
- Accumulator: data/keep registers plus a `lane` counter 0..RATIO-1 and a latched `user` value.
- Beat accepted when `s_axis_tvalid & s_axis_tready`. An accepted beat writes lane `lane`, i.e. bits [64*lane+63 : 64*lane] and keep [8*lane+7 : 8*lane].
- On lane 0 the accepted beat's tuser is latched, and the keep bits of lanes 1..RATIO-1 are zeroed.
- Completion: an accepted beat with `lane == RATIO-1` or `s_axis_tlast == 1`.
  - The completed word, including the current beat, moves to the output register with tlast = `s_axis_tlast`.
  - `lane` returns to 0.
- Non-completing beat: `lane` increments by 1.
- Output register: holds exactly one word. It is cleared when `m_axis_tvalid & m_axis_tready` and no new word is loaded in the same cycle.
- `s_axis_tready = !m_axis_tvalid | m_axis_tready`. This is combinational, with no dependency on s_axis_tvalid or s_axis_tlast.
- Simultaneous drain and load: both are allowed in the same cycle, so output stays valid with the new word and nothing is lost.
- Empty beats (tkeep = 0) carrying tlast are legal. The flushed word keeps the lanes already filled, plus zero keep for that beat.
- Unfilled lanes' tdata is don't-care. The bench checks tdata only under tkeep.

## Timing
- Reset values:
  - `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tkeep` = 0, `m_axis_tdata` = 0, `m_axis_tuser` = 0.
  - `lane` = 0, `err_keep` = 0.
  - `s_axis_tready` = 1 in the first cycle after reset.
- Latency: the word is valid on `m_axis` the cycle after its completing beat is accepted.
- Throughput: one input beat per cycle sustained while downstream drains at least one word per RATIO cycles.
- Backpressure: while `m_axis_tvalid & !m_axis_tready`, `s_axis_tready` = 0. In that state the accumulator and output are frozen and the output is AXI-stable.
- Reset mid-packet discards the partial accumulator and any pending output word. The next accepted beat is treated as lane 0.

## Configuration
- Macro `WIDTH_COMBINER_KEEP_CHECK_EN`.
- When defined:
  - `err_keep` sets on any accepted beat that has `s_axis_tlast == 0` and `s_axis_tkeep != 8'hFF`.
  - It also sets on any tkeep that is non-contiguous.
  - `err_keep` stays set until reset. Data still passes unmodified.
- When undefined: `err_keep` is tied to 0 and the check logic is absent.

## Structure
- Shared package `width_conv_pkg`, common with `width_divider`, holds:
  - RATIO and `LANE_W = clog2(RATIO)`.
  - The contiguous-keep check function.
  - A lane-select helper for the keep mask.
- One sub-module: `axis_out_slice`, a single-entry registered output slice carrying the valid/ready handshake, parameterised on payload width.

## Test plan
- 8-beat packet:
  - Stimulus: beats 64'h0000_0000_0000_0001 … 0008, all tkeep = FF, tlast on beat 8, m_axis_tready = 1.
  - Response: two words. Word 1 = {…0004,…0003,…0002,…0001} with keep FFFFFFFF and tlast 0. Word 2 = {…0008 … …0005} with tlast 1.
  - Each word appears 1 cycle after its 4th beat.
- Short packet:
  - Stimulus: 2 beats, second beat tkeep = 0F with tlast.
  - Response: one word with tkeep = 32'h0000_0FFF and tlast = 1.
- Backpressure:
  - Stimulus: m_axis_tready = 0 for 10 cycles during a 12-beat packet.
  - Response: s_axis_tready drops after the first word completes. No beat is lost or duplicated, and the output stays stable while stalled.
- tuser:
  - Stimulus: first beat tuser = 1, remaining beats tuser = 0.
  - Response: that word's m_axis_tuser = 1; the next word's m_axis_tuser = 0.
- Reset mid-packet:
  - Stimulus: reset after 2 beats, then a fresh 4-beat packet.
  - Response: only the fresh word is emitted, with data in lanes 0..3 in order.
- Keep check (macro defined):
  - Stimulus: non-last beat with tkeep = 7F.
  - Response: err_keep = 1 the next cycle and held. With the macro undefined, err_keep stays 0.
